// File: rtl/serial_deserializer_if.sv
// Handshake bundle for serial_deserializer: serial input side,
// parallel valid/ready output side and status.
interface serial_deserializer_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic             enable;
  logic             din;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             overrun;
  logic [CW-1:0]    bit_count;
  logic             busy;

  modport master (
    output start, enable, din, out_ready,
    input  data_out, out_valid, overrun, bit_count, busy
  );

  modport slave (
    input  start, enable, din, out_ready,
    output data_out, out_valid, overrun, bit_count, busy
  );
endinterface

// File: rtl/serial_deserializer.sv
// LSB-first serial-to-parallel word assembler with valid/ready output.
// Optional DESER_CONTINUOUS_EN: stay in COLLECT after each word.
module serial_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;

  logic             w_sample;
  logic             w_done;
  logic             w_xfer;
  logic [WIDTH-1:0] w_ins;

  assign w_sample = (r_state == COLLECT) & ~bus.start & bus.enable;
  assign w_done   = w_sample & (r_cnt == LAST);
  assign w_xfer   = r_valid & bus.out_ready;

  // Assembly register with the current bit dropped into slot r_cnt
  always_comb begin
    w_ins = r_shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_cnt == CW'(i)) w_ins[i] = bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= COLLECT;
            r_cnt   <= '0;
            r_shift <= '0;
          end
        end
        COLLECT: begin
          if (bus.start) begin
            r_cnt   <= '0;
            r_shift <= '0;
          end else if (bus.enable) begin
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_shift <= '0;
`ifdef DESER_CONTINUOUS_EN
              r_state <= COLLECT;
`else
              r_state <= IDLE;
`endif
            end else begin
              r_cnt   <= r_cnt + CW'(1);
              r_shift <= w_ins;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // A full holding slot that is not drained loses the new word
      if (w_done) begin
        if (!r_valid || bus.out_ready) begin
          r_data  <= w_ins;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.overrun   = r_ovr;
  assign bus.bit_count = r_cnt;
  assign bus.busy      = (r_state == COLLECT);
endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer: directed scenarios
// followed by random traffic against a bit-queue reference model.
module tb_serial_deserializer;
  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_deserializer_if #(.WIDTH(W)) bus();

  serial_deserializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int m_bits[$];
  bit m_active = 0;
  bit m_pend   = 0;
  bit m_ovr    = 0;
  int m_dout   = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic cyc(bit rs, bit st, bit en, bit d, bit rdy);
    int  w;
    bit  done;
    @(posedge clk);
    #1;
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("bit_count", 32'(bus.bit_count), 32'(m_bits.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(m_pend));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    chk("data_out", 32'(bus.data_out), 32'(m_dout));
    reset         = rs;
    bus.start     = st;
    bus.enable    = en;
    bus.din       = d;
    bus.out_ready = rdy;
    if (rs) begin
      m_active = 0;
      m_bits.delete();
      m_pend = 0;
      m_ovr  = 0;
      m_dout = 0;
      exp_q.delete();
    end else begin
      done = 0;
      w    = 0;
      if (st) begin
        m_active = 1;
        m_bits.delete();
      end else if (m_active && en) begin
        m_bits.push_back(int'(d));
        if (m_bits.size() == W) begin
          foreach (m_bits[i]) w += m_bits[i] << i;
          done = 1;
          m_bits.delete();
`ifndef DESER_CONTINUOUS_EN
          m_active = 0;
`endif
        end
      end
      if (done) begin
        if (!m_pend || rdy) begin
          m_pend = 1;
          m_dout = w;
          exp_q.push_back(w);
        end else begin
          m_ovr = 1;
        end
      end else if (m_pend && rdy) begin
        m_pend = 0;
      end
    end
  endtask

  // Monitor: every accepted word must match the scoreboard head
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected got %0h want none", bus.data_out);
      end else begin
        chk("xfer_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.start     = 1'b0;
    bus.enable    = 1'b0;
    bus.din       = 1'b0;
    bus.out_ready = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);

    // Basic word 1,0,1,1 -> 1101
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_data", 32'(bus.data_out), 32'hd);
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'h0);

    // Overrun while holding
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t2_data", 32'(bus.data_out), 32'hd);
    chk("t2_ovr", 32'(bus.overrun), 32'h1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("t2_valid", 32'(bus.out_valid), 32'h0);

    // Same-cycle accept
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("t3_data", 32'(bus.data_out), 32'ha);
    chk("t3_valid", 32'(bus.out_valid), 32'h1);
    chk("t3_ovr", 32'(bus.overrun), 32'h0);

    // Restart mid-frame
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_data", 32'(bus.data_out), 32'h8);

    // Reset mid-frame
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_cnt", 32'(bus.bit_count), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
`ifndef DESER_CONTINUOUS_EN
    chk("t5_noword", 32'(bus.out_valid), 32'h0);
`endif

`ifdef DESER_CONTINUOUS_EN
    // Back-to-back words without a second start
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_busy", 32'(bus.busy), 32'h1);
`endif

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bit rs;
      rs = ($urandom_range(0, 199) == 0);
      cyc(rs,
          ($urandom_range(0, 11) == 0),
          1'($urandom),
          1'($urandom),
          rs ? 1'b0 : 1'($urandom));
    end

    // Drain anything still held
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("drain_q", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
